// File: rtl/demux2x32_buf.sv
// demux2x32_buf: one-to-two word router with a small FIFO per destination.
//
// A single valid/ready input stream is steered to destination A (in_sel=0)
// or destination B (in_sel=1). Each destination owns an independent FIFO,
// so a stalled consumer on one side never blocks traffic to the other.
//
// Ports:
//   clk              rising-edge clock
//   clrn             asynchronous active-low reset (flushes both FIFOs)
//   in_valid/ready   input handshake; in_ready reflects the selected FIFO only
//   in_sel           0 -> A, 1 -> B
//   in_data          input word
//   a_valid/ready    A output handshake, a_data is the A FIFO head (0 if empty)
//   b_valid/ready    B output handshake, b_data is the B FIFO head (0 if empty)
//   a_count/b_count  FIFO occupancy, 0..DEPTH

// Single synchronous FIFO with registered, zero-gated head output.
module demux2x32_buf_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             push_i,   // already qualified against full_o
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             full_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign valid_o = (cnt_q != '0);
    assign pop     = valid_o & ready_i;
    assign data_o  = valid_o ? mem_q[rptr_q] : '0;
    assign count_o = cnt_q;

    // Pointers are power-of-two wide, so natural overflow gives modulo-DEPTH wrap.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_i) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({push_i, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (push_i) begin
                mem_q[wptr_q] <= data_i;
            end
        end
    end
endmodule

module demux2x32_buf #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CW-1:0]    a_count,
    output logic [CW-1:0]    b_count
);
    logic a_full;
    logic b_full;
    logic a_push;
    logic b_push;

    // Full blocks the push even when that FIFO pops in the same cycle.
    assign in_ready = in_sel ? ~b_full : ~a_full;
    assign a_push   = in_valid & ~in_sel & ~a_full;
    assign b_push   = in_valid &  in_sel & ~b_full;

    demux2x32_buf_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo_a (
        .clk     (clk),
        .clrn    (clrn),
        .push_i  (a_push),
        .data_i  (in_data),
        .ready_i (a_ready),
        .full_o  (a_full),
        .valid_o (a_valid),
        .data_o  (a_data),
        .count_o (a_count)
    );

    demux2x32_buf_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo_b (
        .clk     (clk),
        .clrn    (clrn),
        .push_i  (b_push),
        .data_i  (in_data),
        .ready_i (b_ready),
        .full_o  (b_full),
        .valid_o (b_valid),
        .data_o  (b_data),
        .count_o (b_count)
    );
endmodule

// File: tb/tb_demux2x32_buf.sv
module tb_demux2x32_buf;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             clrn;
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic [CW-1:0]    a_count;
    logic [CW-1:0]    b_count;

    int total = 0;
    int bad   = 0;

    // Model: one queue per destination.
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    // Words seen leaving B (sampled from the DUT) and peak B occupancy.
    logic [WIDTH-1:0] b_seen[$];
    int               b_max = 0;

    always #5 clk = ~clk;

    demux2x32_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .clrn     (clrn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update from the spec rules: push if selected queue not full
    // (judged before this edge's pop), pop if queue non-empty and ready.
    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            qa.delete();
            qb.delete();
        end else begin
            automatic bit push_a = in_valid && !in_sel && (qa.size() < DEPTH);
            automatic bit push_b = in_valid &&  in_sel && (qb.size() < DEPTH);
            automatic bit pop_a  = (qa.size() != 0) && a_ready;
            automatic bit pop_b  = (qb.size() != 0) && b_ready;
            if (pop_a) void'(qa.pop_front());
            if (pop_b) void'(qb.pop_front());
            if (push_a) qa.push_back(in_data);
            if (push_b) qb.push_back(in_data);
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("a_valid", {31'b0, a_valid}, {31'b0, qa.size() != 0});
        chk("b_valid", {31'b0, b_valid}, {31'b0, qb.size() != 0});
        chk("a_count", WIDTH'(a_count), WIDTH'(qa.size()));
        chk("b_count", WIDTH'(b_count), WIDTH'(qb.size()));
        chk("a_data", a_data, (qa.size() != 0) ? qa[0] : '0);
        chk("b_data", b_data, (qb.size() != 0) ? qb[0] : '0);
        chk("in_ready", {31'b0, in_ready},
            {31'b0, in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH)});
        if (b_valid && b_ready) b_seen.push_back(b_data);
        if (int'(b_count) > b_max) b_max = int'(b_count);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clrn     = 1'b0;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        tick();
        tick();
        clrn = 1'b1;
        tick();
        chk("lit_reset_a_count", WIDTH'(a_count), 32'd0);
        chk("lit_reset_in_ready", {31'b0, in_ready}, 32'd1);

        // Route: A then B, both readies high.
        a_ready = 1'b1; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h11111111;
        tick();
        chk("lit_route_a_data", a_data, 32'h11111111);
        in_sel = 1'b1; in_data = 32'h22222222;
        tick();
        chk("lit_route_b_data", b_data, 32'h22222222);
        chk("lit_route_a_cnt0", WIDTH'(a_count), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("lit_route_b_cnt0", WIDTH'(b_count), 32'd0);

        // Fill A, then B still accepts.
        a_ready = 1'b0; b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA0;
        tick();
        in_data = 32'hA1;
        tick();
        chk("lit_fill_a_count", WIDTH'(a_count), 32'd2);
        chk("lit_fill_in_ready", {31'b0, in_ready}, 32'd0);
        in_sel = 1'b1; in_data = 32'hB0;
        tick();
        chk("lit_iso_b_valid", {31'b0, b_valid}, 32'd1);
        chk("lit_iso_b_data", b_data, 32'hB0);

        // Full + pop same cycle: no pass-through.
        in_sel = 1'b0; in_data = 32'hA2; a_ready = 1'b1;
        #1;
        chk("lit_full_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        chk("lit_full_pop_cnt", WIDTH'(a_count), 32'd1);
        chk("lit_full_head_a1", a_data, 32'hA1);
        a_ready = 1'b0;
        tick();
        chk("lit_full_push_cnt", WIDTH'(a_count), 32'd2);
        in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        tick();
        chk("lit_order_a2", a_data, 32'hA2);
        tick();
        chk("lit_drained_a", WIDTH'(a_count), 32'd0);

        // Stall stability on B while A traffic flows.
        b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hDEADBEEF;
        tick();
        for (int i = 0; i < 5; i++) begin
            in_sel = 1'b0; in_data = 32'h100 + i;
            tick();
            chk("lit_stall_b_data", b_data, 32'hDEADBEEF);
            chk("lit_stall_b_valid", {31'b0, b_valid}, 32'd1);
        end
        in_valid = 1'b0; b_ready = 1'b1;
        tick();
        tick();

        // Wrap: 8 words to B with b_ready toggling.
        b_seen.delete();
        b_max = 0;
        begin
            int w = 0;
            int cyc = 0;
            while ((b_seen.size() < 8) && (cyc < 60)) begin
                in_valid = (w < 8);
                in_sel   = 1'b1;
                in_data  = WIDTH'(w);
                b_ready  = cyc[0];
                #1;
                if (in_valid && in_ready) w++;
                tick();
                cyc++;
            end
            chk("lit_wrap_count", WIDTH'(b_seen.size()), 32'd8);
        end
        in_valid = 1'b0; b_ready = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("lit_wrap_order", (i < b_seen.size()) ? b_seen[i] : 32'hFFFFFFFF, WIDTH'(i));
        end
        chk("lit_wrap_max", WIDTH'(b_max), 32'd2);

        // Asynchronous reset with a word queued in A.
        a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h55;
        tick();
        in_valid = 1'b0;
        chk("lit_pre_rst_a_valid", {31'b0, a_valid}, 32'd1);
        #1;
        clrn = 1'b0;
        #1;
        chk("lit_rst_a_valid", {31'b0, a_valid}, 32'd0);
        chk("lit_rst_a_count", WIDTH'(a_count), 32'd0);
        chk("lit_rst_a_data", a_data, 32'd0);
        chk("lit_rst_ready_a", {31'b0, in_ready}, 32'd1);
        in_sel = 1'b1;
        #1;
        chk("lit_rst_ready_b", {31'b0, in_ready}, 32'd1);
        tick();
        clrn = 1'b1;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
